// File: rtl/receiver_top.sv
// ---------------------------------------------------------------------------
// receiver_top
//
// Purpose:
//    UART receiver (8N1, idle-high line) with a 16x oversampling front end,
//    break/framing-error handling and a 4-entry first-word-fall-through FIFO
//    for the received bytes.
//
// Parameters:
//    CLK_HZ    system clock frequency in Hz
//    BAUD      serial bit rate
//    TICK_DIV  system clocks per 16x oversample tick
//
// Ports:
//    clk        system clock, all logic on the rising edge
//    reset      synchronous active-high reset
//    RsRx       asynchronous serial input line
//    rd_en      pops the FIFO head when rx_valid is high
//    rx_data    FIFO head byte, 0 when the FIFO is empty
//    rx_valid   FIFO not empty
//    numRx      last correctly framed byte
//    rxDataRdy  one-cycle pulse per correctly framed byte
//    frame_err  one-cycle pulse when a stop bit samples low
//    overflow   sticky, set when a good byte is dropped on a full FIFO
// ---------------------------------------------------------------------------
module receiver_top #(
    parameter int CLK_HZ   = 100000000,
    parameter int BAUD     = 9600,
    parameter int TICK_DIV = CLK_HZ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RsRx,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [7:0] numRx,
    output logic       rxDataRdy,
    output logic       frame_err,
    output logic       overflow
);

    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // -----------------------------------------------------------------------
    // Line synchronizer. Two flops bring RsRx into the clock domain; the third
    // flop only remembers the previous synchronized value for edge detection.
    // All flops reset high so that reset itself never looks like a start edge.
    // -----------------------------------------------------------------------
    logic r_meta;
    logic r_sync;
    logic r_syncPrev;
    logic w_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta     <= 1'b1;
            r_sync     <= 1'b1;
            r_syncPrev <= 1'b1;
        end else begin
            r_meta     <= RsRx;
            r_sync     <= r_meta;
            r_syncPrev <= r_sync;
        end
    end

    assign w_fall = r_syncPrev & ~r_sync;

    // -----------------------------------------------------------------------
    // Free-running 16x oversample tick generator.
    // -----------------------------------------------------------------------
    logic [TW-1:0] r_tickCnt;
    logic          w_tick;

    assign w_tick = (r_tickCnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tickCnt <= '0;
        end else if (w_tick) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + TW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Receive FSM. The start bit is re-checked at its middle (8th tick); from
    // there every 16th tick lands in the middle of the next bit. A low stop
    // bit reports one framing error and parks in BREAK until the line idles,
    // so a line held low does not generate a stream of errors.
    // -----------------------------------------------------------------------
    state_t     r_state;
    logic [3:0] r_sampleCnt;
    logic [2:0] r_bitCnt;
    logic [7:0] r_shift;
    logic [7:0] r_numRx;
    logic       r_rxDataRdy;
    logic       r_frameErr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sampleCnt <= 4'd0;
            r_bitCnt    <= 3'd0;
            r_shift     <= 8'h00;
            r_numRx     <= 8'h00;
            r_rxDataRdy <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            r_rxDataRdy <= 1'b0;
            r_frameErr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state     <= S_START;
                        r_sampleCnt <= 4'd0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_sampleCnt == 4'd7) begin
                            r_sampleCnt <= 4'd0;
                            if (r_sync) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state  <= S_DATA;
                                r_bitCnt <= 3'd0;
                            end
                        end else begin
                            r_sampleCnt <= r_sampleCnt + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        // The 4-bit sample counter wraps 15 -> 0 on its own.
                        r_sampleCnt <= r_sampleCnt + 4'd1;
                        if (r_sampleCnt == 4'd15) begin
                            r_shift  <= {r_sync, r_shift[7:1]};
                            r_bitCnt <= r_bitCnt + 3'd1;
                            if (r_bitCnt == 3'd7) begin
                                r_state <= S_STOP;
                            end
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_sampleCnt <= r_sampleCnt + 4'd1;
                        if (r_sampleCnt == 4'd15) begin
                            if (r_sync) begin
                                r_numRx     <= r_shift;
                                r_rxDataRdy <= 1'b1;
                                r_state     <= S_IDLE;
                            end else begin
                                r_frameErr <= 1'b1;
                                r_state    <= S_BREAK;
                            end
                        end
                    end
                end
                S_BREAK: begin
                    if (r_sync) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // 4-entry FIFO. A byte is offered while rxDataRdy is high. A pop in the
    // same cycle frees the slot, so a full FIFO still accepts the byte then;
    // only a push on a full FIFO without a pop drops the byte.
    // -----------------------------------------------------------------------
    logic [7:0] r_mem [4];
    logic [1:0] r_wrPtr;
    logic [1:0] r_rdPtr;
    logic [2:0] r_count;
    logic       r_overflow;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;

    assign w_empty = (r_count == 3'd0);
    assign w_full  = (r_count == 3'd4);
    assign w_pop   = rd_en & ~w_empty;
    assign w_push  = r_rxDataRdy & (~w_full | w_pop);
    assign w_drop  = r_rxDataRdy & w_full & ~w_pop;

    // Storage has no reset; entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= r_numRx;
        end
    end

    // Pointer, occupancy and overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr    <= 2'd0;
            r_rdPtr    <= 2'd0;
            r_count    <= 3'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 2'd1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rx_valid  = ~w_empty;
    assign rx_data   = w_empty ? 8'h00 : r_mem[r_rdPtr];
    assign numRx     = r_numRx;
    assign rxDataRdy = r_rxDataRdy;
    assign frame_err = r_frameErr;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_receiver_top.sv
// ---------------------------------------------------------------------------
// tb_receiver_top
//
// Purpose:
//    Self-checking bench for receiver_top. Serial frames are driven on RsRx;
//    each good byte is pushed to a received-byte scoreboard and to a FIFO
//    model, and popped/compared when the DUT pulses rxDataRdy or when the
//    bench reads the FIFO.
// ---------------------------------------------------------------------------
module tb_receiver_top;

    localparam int TICK_DIV = 4;
    localparam int BIT      = 16 * TICK_DIV;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       RsRx  = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] numRx;
    logic       rxDataRdy;
    logic       frame_err;
    logic       overflow;

    int checks      = 0;
    int errors      = 0;
    int frameErrCnt = 0;

    logic [7:0] expRx[$];
    logic [7:0] fifoModel[$];
    logic       expOverflow = 1'b0;
    logic [7:0] monExp;

    typedef struct {
        logic [7:0] data;
        logic       stopOk;
    } vec_t;

    vec_t vecs[5];

    receiver_top #(
        .CLK_HZ  (640000),
        .BAUD    (10000),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .RsRx     (RsRx),
        .rd_en    (rd_en),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .numRx    (numRx),
        .rxDataRdy(rxDataRdy),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive one frame; stop bit optionally low, then optionally held low.
    task automatic applyStimulus(input logic [7:0] b, input logic stopOk,
                                 input int holdLowBits);
        if (stopOk) begin
            expRx.push_back(b);
            if (fifoModel.size() < 4) fifoModel.push_back(b);
            else expOverflow = 1'b1;
        end
        RsRx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RsRx = b[i];
            repeat (BIT) @(negedge clk);
        end
        RsRx = stopOk;
        repeat (BIT) @(negedge clk);
        repeat (holdLowBits * BIT) @(negedge clk);
        RsRx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
    endtask

    // Compare the FIFO head against the model and pop it.
    task automatic popCheck(input string name);
        logic [7:0] e;
        e = 8'h00;
        checkOutput({name, "_valid"}, 32'(rx_valid), 32'd1);
        if (fifoModel.size() > 0) e = fifoModel.pop_front();
        checkOutput(name, 32'(rx_data), 32'(e));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // Scoreboard side: every rxDataRdy pulse must match the oldest sent byte.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err === 1'b1) frameErrCnt++;
            if (rxDataRdy === 1'b1) begin
                if (expRx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedRxDataRdy numRx=%02h expected no pulse", numRx);
                end else begin
                    monExp = expRx.pop_front();
                    checkOutput("numRx", 32'(numRx), 32'(monExp));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         fe0;
        int         found;
        logic [7:0] headExp;
        logic [7:0] partial;

        vecs[0] = '{8'hA5, 1'b1};
        vecs[1] = '{8'h00, 1'b1};
        vecs[2] = '{8'hFF, 1'b1};
        vecs[3] = '{8'h5A, 1'b0};
        vecs[4] = '{8'h81, 1'b1};

        // Reset state
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstNumRx", 32'(numRx), 32'h0);
        checkOutput("rstRdy", 32'(rxDataRdy), 32'h0);
        checkOutput("rstFrameErr", 32'(frame_err), 32'h0);
        checkOutput("rstOverflow", 32'(overflow), 32'h0);
        checkOutput("rstValid", 32'(rx_valid), 32'h0);
        checkOutput("rstData", 32'(rx_data), 32'h0);

        // Reads on an empty FIFO are ignored
        rd_en = 1'b1;
        repeat (3) @(negedge clk);
        rd_en = 1'b0;
        checkOutput("emptyPopValid", 32'(rx_valid), 32'h0);
        checkOutput("emptyPopData", 32'(rx_data), 32'h0);

        // Table-driven single frames
        for (int i = 0; i < 5; i++) begin
            fe0 = frameErrCnt;
            applyStimulus(vecs[i].data, vecs[i].stopOk, 0);
            checkOutput("tablePending", 32'(expRx.size()), 32'd0);
            checkOutput("tableFrameErr", 32'(frameErrCnt - fe0), vecs[i].stopOk ? 32'd0 : 32'd1);
            if (vecs[i].stopOk) begin
                popCheck("tableHead");
                checkOutput("tableEmptyAfterPop", 32'(rx_valid), 32'h0);
            end else begin
                checkOutput("tableNoValid", 32'(rx_valid), 32'h0);
            end
        end

        // Short low glitch is a false start
        fe0 = frameErrCnt;
        RsRx = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        RsRx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        checkOutput("glitchFrameErr", 32'(frameErrCnt - fe0), 32'd0);
        checkOutput("glitchValid", 32'(rx_valid), 32'h0);

        // Bad stop bit then long break: exactly one frame error
        fe0 = frameErrCnt;
        applyStimulus(8'h3C, 1'b0, 20);
        applyStimulus(8'h7E, 1'b1, 0);
        checkOutput("breakFrameErr", 32'(frameErrCnt - fe0), 32'd1);
        checkOutput("breakPending", 32'(expRx.size()), 32'd0);
        popCheck("breakHead");
        checkOutput("breakEmpty", 32'(rx_valid), 32'h0);

        // Five bytes, no reads: fifth dropped
        for (int v = 1; v <= 5; v++) applyStimulus(8'(v), 1'b1, 0);
        checkOutput("ovfFlag", 32'(overflow), 32'(expOverflow));
        checkOutput("ovfNumRx", 32'(numRx), 32'h05);
        checkOutput("ovfPending", 32'(expRx.size()), 32'd0);
        for (int k = 0; k < 4; k++) popCheck("ovfHead");
        checkOutput("ovfEmpty", 32'(rx_valid), 32'h0);

        // Reset during bit 4 of 0x55
        partial = 8'h55;
        RsRx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RsRx = partial[i];
            repeat (BIT) @(negedge clk);
        end
        RsRx = partial[4];
        repeat (BIT / 2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expOverflow = 1'b0;
        fifoModel.delete();
        RsRx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        checkOutput("midRstOverflow", 32'(overflow), 32'h0);
        checkOutput("midRstNumRx", 32'(numRx), 32'h0);
        applyStimulus(8'hC3, 1'b1, 0);
        checkOutput("midRstPending", 32'(expRx.size()), 32'd0);
        popCheck("midRstHead");
        checkOutput("midRstOverflow2", 32'(overflow), 32'h0);

        // Full FIFO: pop in the same cycle as the push of 0x99
        applyStimulus(8'h11, 1'b1, 0);
        applyStimulus(8'h22, 1'b1, 0);
        applyStimulus(8'h33, 1'b1, 0);
        applyStimulus(8'h44, 1'b1, 0);
        headExp = fifoModel.pop_front();
        found = 0;
        fork
            applyStimulus(8'h99, 1'b1, 0);
            begin
                for (int n = 0; n < 20 * BIT && found == 0; n++) begin
                    @(negedge clk);
                    if (rxDataRdy === 1'b1) begin
                        found = 1;
                        checkOutput("simulHead", 32'(rx_data), 32'(headExp));
                        rd_en = 1'b1;
                        @(negedge clk);
                        rd_en = 1'b0;
                    end
                end
                if (found == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL simulTimeout rxDataRdy=0 expected a pulse");
                end
            end
        join
        checkOutput("simulOverflow", 32'(overflow), 32'h0);
        for (int k = 0; k < 4; k++) popCheck("simulHead");
        checkOutput("simulEmpty", 32'(rx_valid), 32'h0);
        checkOutput("simulPending", 32'(expRx.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/receiver_top.md
RECEIVER_TOP -- requirements
Module: receiver_top

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, the system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, the serial bit rate.
REQ-003 The block SHALL have parameter TICK_DIV, default CLK_HZ/(BAUD*16) (651), the clocks per 16x oversample tick.
REQ-004 Port clk, input, 1 bit: the single system clock; all logic SHALL run on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port RsRx, input, 1 bit: asynchronous UART line, 8N1, idle high.
REQ-007 Port rd_en, input, 1 bit: pops the FIFO head when rx_valid=1.
REQ-008 Port rx_data, output, 8 bits: FIFO head (first-word fall-through); 0 when empty.
REQ-009 Port rx_valid, output, 1 bit: FIFO not empty.
REQ-010 Port numRx, output, 8 bits: last correctly framed byte.
REQ-011 Port rxDataRdy, output, 1 bit: one-cycle pulse per correctly framed byte.
REQ-012 Port frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-013 Port overflow, output, 1 bit: sticky flag, set when a good byte is dropped because the FIFO is full.

Function
REQ-014 RsRx SHALL pass a 2-flop synchronizer; all decisions use the synchronized value.
REQ-015 A free-running tick counter SHALL count 0..TICK_DIV-1 and emit a one-clk tick at wrap.
REQ-016 The FSM SHALL have states IDLE, START, DATA and STOP, plus a BREAK state.
REQ-017 IDLE: on a synchronized falling edge, go to START and clear the sample counter.
REQ-018 START: at tick 8 the line is sampled; high means a false start and a return to IDLE; low means go to DATA with the sample counter cleared.
REQ-019 DATA: every 16th tick samples one bit, LSB first, into a shift register; after bit 7 the FSM goes to STOP.
REQ-020 STOP: the 16th tick samples the stop bit; high means a good byte and a return to IDLE.
REQ-021 STOP with the stop bit low: pulse frame_err, discard the byte, and go to BREAK.
REQ-022 BREAK: leave only when the synchronized line is high, then go to IDLE, so a held-low line yields exactly one frame_err.
REQ-023 On a good byte, numRx SHALL update and rxDataRdy SHALL pulse in the clk following the stop-bit sample tick.
REQ-024 On a good byte with the FIFO not full, the byte SHALL be pushed in the same cycle that rxDataRdy pulses.
REQ-025 The FIFO SHALL be 4 entries, with 2-bit pointers that wrap 3->0 and a 3-bit count.
REQ-026 Push and pop in the same cycle SHALL both take effect, and count is unchanged.
REQ-027 Push and pop in the same cycle with the FIFO full SHALL both succeed, with no overflow.
REQ-028 A push with the FIFO full and no pop SHALL drop the byte and set overflow.
REQ-029 When the FIFO is dropping a byte, numRx and rxDataRdy SHALL still update.
REQ-030 rd_en with the FIFO empty SHALL be ignored and SHALL NOT change the pointers.
REQ-031 rx_data and rx_valid SHALL reflect the FIFO state registered at the same edge as a push or pop, with zero added latency.

Reset
REQ-032 When reset=1 at a clk edge, the FSM SHALL go to IDLE, and the tick, sample and bit counters, FIFO pointers and count SHALL clear.
REQ-033 After reset, numRx=0, rxDataRdy=0, frame_err=0, overflow=0, rx_valid=0 and rx_data=0.
REQ-034 The synchronizer flops SHALL reset to 1.
REQ-035 Reset mid-frame SHALL abandon the frame with no pulse; the next falling edge after reset starts a new frame.

Verification
REQ-036 Send 0xA5 at 9600 baud -> one rxDataRdy pulse, numRx=0xA5, rx_valid=1, rx_data=0xA5; rd_en pulse -> rx_valid=0.
REQ-037 Send 0x01,0x02,0x03,0x04,0x05 with no reads -> the FIFO holds 01..04, overflow=1, numRx=0x05; 4 pops return 01,02,03,04 in order.
REQ-038 Send a low glitch of 4 ticks -> no state change beyond START, no pulses, rx_valid stays 0.
REQ-039 Send 0x3C with the stop bit low, then hold the line low 20 bit times, then send 0x7E -> exactly one frame_err pulse; only 0x7E is received.
REQ-040 Assert reset during bit 4 of 0x55, then send 0xC3 -> no pulse for 0x55; 0xC3 is received correctly and overflow=0.
REQ-041 With the FIFO full, pop in the same cycle as the push of 0x99 -> count stays 4, overflow=0, and 0x99 is the last entry.
